// File: rtl/bin8_to_dec_seq.sv
// Iterative double-dabble converter: 8-bit binary to three registered BCD digits,
// driving three active-low 7-segment displays with optional leading-zero blanking.
module bin8_to_dec_seq #(
  parameter bit BLANK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [11:0] o_bcd,
  output logic [0:6]  o_hex2,
  output logic [0:6]  o_hex1,
  output logic [0:6]  o_hex0
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t      r_state;
  logic [19:0] r_scratch;
  logic [2:0]  r_cnt;
  logic [11:0] r_bcd;
  logic        r_done;

  logic [19:0] w_adj;
  logic        w_blank2;
  logic        w_blank1;

  // One shared add-3 stage applied to all three BCD nibbles; no inter-nibble carry.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < 3; i++) begin
      if (r_scratch[8 + 4*i +: 4] >= 4'd5) begin
        w_adj[8 + 4*i +: 4] = r_scratch[8 + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_scratch <= {12'b0, i_bin};
            r_cnt     <= '0;
            r_state   <= StShift;
          end
        end
        StShift: begin
          r_scratch <= w_adj << 1;
          r_cnt     <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_bcd   <= r_scratch[19:8];
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_blank2 = BLANK && (r_bcd[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);

  assign o_busy = (r_state != StIdle);
  assign o_done = r_done;
  assign o_bcd  = r_bcd;
  assign o_hex2 = w_blank2 ? 7'b1111111 : seg7(r_bcd[11:8]);
  assign o_hex1 = w_blank1 ? 7'b1111111 : seg7(r_bcd[7:4]);
  assign o_hex0 = seg7(r_bcd[3:0]);

endmodule

// File: doc/bin8_to_dec_seq.md
# bin8_to_dec_seq

Sequential binary-to-decimal converter and display controller for the DE1-SoC 7-segment bank. It accepts an 8-bit unsigned value (0–255) with a start handshake and runs an iterative shift-and-add-3 (double-dabble) conversion. It registers the three resulting BCD digits and drives HEX2..HEX0 with leading-zero blanking. It replaces per-value combinational comparator/mux adjust logic with one shared, sequenced adjust stage.

## Interface
- BLANK, 1, 1 = blank leading zero digits on HEX2/HEX1; 0 = always show all three digits

- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Start  in  1  request a conversion; sampled only in IDLE
- Bin  in  8  unsigned value to convert; captured on the accepting edge
- Busy  out  1  high while a conversion is in progress (state != IDLE)
- Done  out  1  registered one-cycle pulse when the result is loaded
- BCD  out  12  registered result {hundreds, tens, ones}, 4 bits each
- HEX2  out  [0:6]  hundreds digit, active-LOW segments a..g
- HEX1  out  [0:6]  tens digit, active-LOW
- HEX0  out  [0:6]  ones digit, active-LOW

## Operation
- State machine:
  - IDLE: if Start=1, load scratch = {12'b0, Bin}, clear iteration counter, go to SHIFT. Otherwise stay.
  - SHIFT: one iteration per cycle. For each 4-bit BCD nibble of scratch[19:8] that is >= 5, add 3. Then shift the whole 20-bit scratch left by 1. Increment the counter (3 bits). After the 8th iteration (counter == 7), go to DONE.
  - DONE: BCD <= scratch[19:8], Done <= 1, go to IDLE.
- Done is 0 in every cycle except the one following the DONE edge.
- Busy is decoded from the registered state.
- Start is ignored while Busy=1. It is not queued.
- Bin is don't-care except on the accepting edge.
- The hundreds nibble never exceeds 2. Nibble add-3 stays within 4 bits; there is no carry between nibbles.
- BCD and HEX outputs hold the previous result during a conversion and change only on the DONE edge.
- Segment encoding, active-LOW abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- Leading-zero blanking (BLANK=1):
  - HEX2 is blank when hundreds=0.
  - HEX1 is blank when hundreds=0 and tens=0.
  - HEX0 is never blank.
- Segment outputs are combinational decodes of the BCD register, so they are glitch-free with respect to the scratch register.

## Timing
- Start accepted at edge E0.
- Iterations occur on edges E1..E8.
- DONE transition occurs on edge E9.
- Busy is high after E0 through the cycle after E8, and low from E9.
- Done is high for exactly the cycle after E9. BCD is valid from E9.
- Start high in the Done cycle is accepted at E9+1.
- The back-to-back conversion period is 10 cycles.
- Reset values (immediate, asynchronous):
  - state=IDLE, Busy=0, Done=0, BCD=12'h000, scratch=0, counter=0
  - HEX0=0000001
  - HEX1 and HEX2 = 1111111 when BLANK=1, 0000001 when BLANK=0
- Reset mid-conversion aborts it. No Done pulse is produced, and outputs go to their reset values.
- Reset deasserting with Start=1 is accepted on the first rising edge at which Reset=0.

## Test plan
- Reset, BLANK=1: assert Reset with no clock edge. Required: BCD=000, Busy=0, Done=0, HEX0=0000001, HEX1=HEX2=1111111.
- Bin=255, one-cycle Start at E0. Required:
  - Busy high for 9 cycles, Done high in the single cycle after E9.
  - BCD=12'h255, HEX2=0010010, HEX1=0100100, HEX0=0100100.
- Blanking:
  - Bin=9: HEX2=HEX1=1111111, HEX0=0000100.
  - Bin=100: HEX2=1001111, HEX1=0000001, HEX0=0000001.
  - BLANK=0 with Bin=9: HEX2=HEX1=0000001.
- Start held high while Bin changes every cycle. Required:
  - A Done pulse every 10 cycles.
  - Each result equals Bin at its accepting edge.
  - Start and Bin changes during Busy have no effect, and BCD stays stable until the next Done.
- Convert 200, assert Reset after E4. Required: outputs reset immediately and no Done follows. Then Start with Bin=37 gives BCD=12'h037 with Done after E9.
- Exhaustive sweep of Bin=0..255. Required: each BCD equals {Bin/100, (Bin/10)%10, Bin%10}, and segments match the encoding table.
